sseg_scan_decoder: RTL and testbench
====================================

// Module: sseg_scan_decoder
// PURPOSE
//  Receive end of the multiplexed 7-segment display interface that our display drivers produce.
//  Samples the scanned anode/segment bus and debounces each digit dwell.
//  Decodes the segment patterns back into four digit codes plus decimal points.
//  Used by benches and on-chip self-test to check displayed values (for example sign-magnitude adder results).
// PARAMETERS
//  STABLE_CNT  4     consecutive identical samples needed before a digit is captured (2..15)
//  TIMEOUT     1024  cycles allowed without a completed frame before stale_amisha asserts (>= 8)
// PORTS
//  clk_amisha        in   1   system clock, rising edge
//  reset_amisha      in   1   synchronous reset, active-high
//  an_amisha         in   4   anode enables, active-low, one-hot when a digit is lit
//  sseg_amisha       in   8   segments, active-low: [7]=dp, [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g
//  digit_val_amisha  out  16  decoded hex value per digit; digit i in [4i+3:4i]; 0 unless class is HEX
//  digit_cls_amisha  out  8   class per digit, 2 bits each at [2i+1:2i]: 0=HEX, 1=MINUS, 2=BLANK, 3=INVALID
//  dp_amisha         out  4   decimal point per digit, 1 = lit
//  frame_tick_amisha out  1   1-cycle pulse when all four digits have been captured since the last pulse
//  stale_amisha      out  1   1 = no frame completed within TIMEOUT cycles
//  err_amisha        out  1   sticky: an anode pattern with 2 or more low bits was seen; cleared only by reset
// BEHAVIOUR
//  Reset:
//   - all outputs 0 except digit_cls_amisha = 8'hAA (all BLANK).
//   - capture mask, stability counter and timeout counter are cleared.
//  Input stage: {an, sseg} is registered once (sample s); all logic works on s.
//  Stability counter cnt (4 bits):
//   - cnt <= 1 when s differs from the previous s; otherwise cnt increments, saturating at STABLE_CNT.
//  Capture:
//   - occurs once per dwell, in the cycle where cnt becomes STABLE_CNT, if s.an has exactly one low bit i.
//   - writes digit i val/cls/dp on that edge; sets mask bit i.
//   - latency: when the bus is held from before edge 1, digit i updates at edge STABLE_CNT+2.
//  No capture in these cases:
//   - s.an == 4'hF (blanking gap): no error.
//   - two or more low anode bits: err_amisha <= 1 on the edge where cnt becomes STABLE_CNT.
//  Decode, sseg[6:0] (a..g) -> class/val; any other pattern gives INVALID, val 0:
//   - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
//   - 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F
//   - 1111110=MINUS, 1111111=BLANK
//  dp_amisha[i] <= ~sseg[7] at capture.
//  Frame FSM, 2 states:
//   - COLLECT: when a capture makes mask == 4'hF, go to TICK.
//   - TICK: frame_tick_amisha=1 for 1 cycle, mask <= 0, return to COLLECT.
//   - A capture during TICK is not lost; it sets its bit in the freshly cleared mask.
//   - Recapturing a digit already in the mask updates its value and leaves the mask unchanged.
//  Timeout:
//   - counter tcnt clears on frame_tick_amisha and increments otherwise.
//   - at tcnt == TIMEOUT-1: stale_amisha <= 1 and tcnt holds.
//   - stale_amisha clears on the next frame_tick_amisha.
//  Reset mid-dwell or mid-frame: partial captures are discarded; a full new dwell of STABLE_CNT samples is needed.
// TESTING (STABLE_CNT=4, TIMEOUT=64)
//  1. Hold an=1110, sseg=8'hFF, then an=1110, sseg=8'b1_0000001 for 10 cycles
//     -> digit0 cls=HEX, val=0 at edge 6 of the hold; dp0=0; no tick.
//  2. Scan 0111/1111110, 1011/0000110, 1101/1001111, 1110/0000000, 8 cycles each
//     -> display shows -318: digit_val=16'h0318, digit_cls=8'b01_00_00_00; one tick after the 4th capture.
//  3. Glitch: change sseg every 3 cycles while an=1110 -> no capture; after 64 cycles stale=1.
//     Then run a full scan -> tick pulses and stale drops to 0.
//  4. an=1100 held 8 cycles -> err=1, no capture, remains 1 after valid scans until reset.
//  5. sseg=8'b0_1010101 (dp lit, undefined pattern) on digit2 -> cls2=INVALID, val2=0, dp2=1.
//  6. Assert reset after 2 digits captured -> all cls BLANK, mask 0.
//     The next tick needs 4 fresh captures.

Source files
------------

// File: rtl/sseg_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: samples the anode/segment bus, debounces
// each digit dwell and decodes the segment patterns back into digit codes and decimal points.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk_amisha,
  input  logic        reset_amisha,
  input  logic [3:0]  an_amisha,
  input  logic [7:0]  sseg_amisha,
  output logic [15:0] digit_val_amisha,
  output logic [7:0]  digit_cls_amisha,
  output logic [3:0]  dp_amisha,
  output logic        frame_tick_amisha,
  output logic        stale_amisha,
  output logic        err_amisha
);

  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]  SC    = 4'(STABLE_CNT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ClsHex     = 2'd0,
    ClsMinus   = 2'd1,
    ClsBlank   = 2'd2,
    ClsInvalid = 2'd3
  } cls_e;

  typedef enum logic {
    StCollect,
    StTick
  } state_e;

  logic [11:0]   r_s;
  logic [11:0]   r_p1;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_d;
  logic          r_hit;
  logic [3:0]    w_an;
  logic [7:0]    w_seg;
  logic [1:0]    w_idx;
  logic          w_onehot;
  logic          w_multi;
  cls_e          w_cls;
  logic [3:0]    w_val;
  logic          w_cap;
  logic          w_err_set;
  logic [3:0]    w_bit;
  logic [3:0]    w_mask_or;
  state_e        r_state;
  state_e        w_state_d;
  logic [3:0]    r_mask;
  logic [3:0]    w_mask_d;
  logic [15:0]   r_val;
  logic [7:0]    r_cls;
  logic [3:0]    r_dp;
  logic          r_err;
  logic          r_stale;
  logic [TW-1:0] r_tcnt;
  logic          w_tick;

  // Idle value is a blanking gap so a bus held through reset still needs a full dwell.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      r_s   <= 12'hFFF;
      r_p1  <= 12'hFFF;
      r_cnt <= 4'd0;
      r_hit <= 1'b0;
    end else begin
      r_s   <= {an_amisha, sseg_amisha};
      r_p1  <= r_s;
      r_cnt <= w_cnt_d;
      r_hit <= (w_cnt_d == SC) && (r_cnt != SC);
    end
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (r_s != r_p1) begin
      w_cnt_d = 4'd1;
    end else if (r_cnt != SC) begin
      w_cnt_d = r_cnt + 4'd1;
    end
  end

  // r_p1 still holds the settled value in the cycle after the counter saturates.
  assign w_an  = r_p1[11:8];
  assign w_seg = r_p1[7:0];

  always_comb begin
    w_idx    = 2'd0;
    w_onehot = 1'b0;
    w_multi  = 1'b0;
    unique case (w_an)
      4'b1110: begin w_idx = 2'd0; w_onehot = 1'b1; end
      4'b1101: begin w_idx = 2'd1; w_onehot = 1'b1; end
      4'b1011: begin w_idx = 2'd2; w_onehot = 1'b1; end
      4'b0111: begin w_idx = 2'd3; w_onehot = 1'b1; end
      4'b1111: ;
      default: w_multi = 1'b1;
    endcase
  end

  always_comb begin
    w_cls = ClsHex;
    w_val = 4'h0;
    unique case (w_seg[6:0])
      7'b0000001: w_val = 4'h0;
      7'b1001111: w_val = 4'h1;
      7'b0010010: w_val = 4'h2;
      7'b0000110: w_val = 4'h3;
      7'b1001100: w_val = 4'h4;
      7'b0100100: w_val = 4'h5;
      7'b0100000: w_val = 4'h6;
      7'b0001111: w_val = 4'h7;
      7'b0000000: w_val = 4'h8;
      7'b0000100: w_val = 4'h9;
      7'b0001000: w_val = 4'hA;
      7'b1100000: w_val = 4'hB;
      7'b0110001: w_val = 4'hC;
      7'b1000010: w_val = 4'hD;
      7'b0110000: w_val = 4'hE;
      7'b0111000: w_val = 4'hF;
      7'b1111110: w_cls = ClsMinus;
      7'b1111111: w_cls = ClsBlank;
      default:    w_cls = ClsInvalid;
    endcase
  end

  assign w_cap     = r_hit && w_onehot;
  assign w_err_set = r_hit && w_multi;
  assign w_bit     = 4'b0001 << w_idx;
  assign w_mask_or = r_mask | w_bit;
  assign w_tick    = (r_state == StTick);

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      r_state <= StCollect;
      r_mask  <= 4'h0;
    end else begin
      r_state <= w_state_d;
      r_mask  <= w_mask_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_mask_d  = r_mask;
    unique case (r_state)
      StCollect: begin
        if (w_cap) begin
          w_mask_d = w_mask_or;
          if (w_mask_or == 4'hF) begin
            w_state_d = StTick;
          end
        end
      end
      StTick: begin
        // A capture landing in the tick cycle seeds the next frame.
        w_mask_d  = w_cap ? w_bit : 4'h0;
        w_state_d = StCollect;
      end
      default: w_state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      r_val <= 16'h0000;
      r_cls <= 8'hAA;
      r_dp  <= 4'h0;
      r_err <= 1'b0;
    end else begin
      if (w_cap) begin
        r_val[{w_idx, 2'b00} +: 4] <= w_val;
        r_cls[{w_idx, 1'b0} +: 2]  <= w_cls;
        r_dp[w_idx]                <= ~w_seg[7];
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      r_tcnt  <= '0;
      r_stale <= 1'b0;
    end else if (w_tick) begin
      r_tcnt  <= '0;
      r_stale <= 1'b0;
    end else if (r_tcnt == TLAST) begin
      r_stale <= 1'b1;
    end else begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  assign digit_val_amisha  = r_val;
  assign digit_cls_amisha  = r_cls;
  assign dp_amisha         = r_dp;
  assign frame_tick_amisha = w_tick;
  assign stale_amisha      = r_stale;
  assign err_amisha        = r_err;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Self-checking bench for sseg_scan_decoder: hand sequences for latency, timeout, error and
// reset corners, plus a vector table checked through a scoreboard queue.
module tb_sseg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [7:0]  ss;
  logic [15:0] digit_val;
  logic [7:0]  digit_cls;
  logic [3:0]  dp;
  logic        frame_tick;
  logic        stale;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int tick_cnt = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] ss;
    int         idx;
    logic [1:0] cls;
    logic [3:0] val;
    logic       dp;
  } vec_t;

  vec_t vecs[20];
  vec_t sb[$];

  sseg_scan_decoder #(
    .STABLE_CNT(4),
    .TIMEOUT   (64)
  ) dut (
    .clk_amisha       (clk),
    .reset_amisha     (rst),
    .an_amisha        (an),
    .sseg_amisha      (ss),
    .digit_val_amisha (digit_val),
    .digit_cls_amisha (digit_cls),
    .dp_amisha        (dp),
    .frame_tick_amisha(frame_tick),
    .stale_amisha     (stale),
    .err_amisha       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_tick === 1'b1) tick_cnt <= tick_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    ss = s;
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [3:0] a, input logic [7:0] s, input int idx,
                              input logic [1:0] cls, input logic [3:0] val, input logic d);
    vec_t v;
    v.an = a; v.ss = s; v.idx = idx; v.cls = cls; v.val = val; v.dp = d;
    return v;
  endfunction

  initial begin
    vec_t e;
    logic [3:0] model_mask;
    int exp_ticks;
    int t0;

    vecs[0]  = mk(4'hE, 8'h81, 0, 2'd0, 4'h0, 1'b0);
    vecs[1]  = mk(4'hD, 8'h4F, 1, 2'd0, 4'h1, 1'b1);
    vecs[2]  = mk(4'hB, 8'h92, 2, 2'd0, 4'h2, 1'b0);
    vecs[3]  = mk(4'h7, 8'h06, 3, 2'd0, 4'h3, 1'b1);
    vecs[4]  = mk(4'hE, 8'hCC, 0, 2'd0, 4'h4, 1'b0);
    vecs[5]  = mk(4'hD, 8'hA4, 1, 2'd0, 4'h5, 1'b0);
    vecs[6]  = mk(4'hB, 8'h20, 2, 2'd0, 4'h6, 1'b1);
    vecs[7]  = mk(4'h7, 8'h8F, 3, 2'd0, 4'h7, 1'b0);
    vecs[8]  = mk(4'hE, 8'h00, 0, 2'd0, 4'h8, 1'b1);
    vecs[9]  = mk(4'hD, 8'h84, 1, 2'd0, 4'h9, 1'b0);
    vecs[10] = mk(4'hB, 8'h88, 2, 2'd0, 4'hA, 1'b0);
    vecs[11] = mk(4'h7, 8'h60, 3, 2'd0, 4'hB, 1'b1);
    vecs[12] = mk(4'hE, 8'hB1, 0, 2'd0, 4'hC, 1'b0);
    vecs[13] = mk(4'hD, 8'hC2, 1, 2'd0, 4'hD, 1'b0);
    vecs[14] = mk(4'hB, 8'h30, 2, 2'd0, 4'hE, 1'b1);
    vecs[15] = mk(4'h7, 8'hB8, 3, 2'd0, 4'hF, 1'b0);
    vecs[16] = mk(4'hE, 8'hFE, 0, 2'd1, 4'h0, 1'b0);
    vecs[17] = mk(4'hD, 8'h7F, 1, 2'd2, 4'h0, 1'b1);
    vecs[18] = mk(4'hB, 8'h55, 2, 2'd3, 4'h0, 1'b1);
    vecs[19] = mk(4'h7, 8'hFD, 3, 2'd3, 4'h0, 1'b0);

    // Reset state
    rst = 1'b1;
    drive(4'hF, 8'hFF, 3);
    chk("rst_val", 32'(digit_val), 32'h0);
    chk("rst_cls", 32'(digit_cls), 32'hAA);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    // Glitching bus never settles; stale rises exactly TIMEOUT edges after reset
    for (int k = 0; k < 21; k++) drive(4'hE, (k % 2 == 1) ? 8'hCF : 8'h81, 3);
    chk("stale_before_limit", 32'(stale), 32'h0);
    drive(4'hE, 8'h92, 1);
    chk("stale_at_limit", 32'(stale), 32'h1);
    chk("glitch_no_capture_cls", 32'(digit_cls), 32'hAA);
    chk("glitch_no_capture_val", 32'(digit_val), 32'h0);
    chk("glitch_no_tick", 32'(tick_cnt), 32'h0);
    t0 = tick_cnt;

    // Scan -318; tick exactly one cycle after the 4th capture
    drive(4'h7, 8'hFE, 8);
    drive(4'hB, 8'h86, 8);
    drive(4'hD, 8'hCF, 8);
    drive(4'hE, 8'h80, 5);
    chk("tick_before_4th", 32'(frame_tick), 32'h0);
    drive(4'hE, 8'h80, 1);
    chk("tick_pulse", 32'(frame_tick), 32'h1);
    drive(4'hE, 8'h80, 1);
    chk("tick_one_cycle", 32'(frame_tick), 32'h0);
    chk("stale_cleared", 32'(stale), 32'h0);
    drive(4'hE, 8'h80, 1);
    chk("scan_val", 32'(digit_val), 32'h0318);
    chk("scan_cls", 32'(digit_cls), 32'h40);
    chk("scan_dp", 32'(dp), 32'h0);
    chk("scan_tick_count", 32'(tick_cnt), 32'(t0 + 1));

    // Capture latency: new pattern appears at edge STABLE_CNT+2 of its hold
    drive(4'hE, 8'hFF, 8);
    chk("blank_cls0", 32'(digit_cls[1:0]), 32'h2);
    drive(4'hE, 8'h81, 5);
    chk("lat_edge5_cls0", 32'(digit_cls[1:0]), 32'h2);
    drive(4'hE, 8'h81, 1);
    chk("lat_edge6_cls0", 32'(digit_cls[1:0]), 32'h0);
    chk("lat_edge6_val", 32'(digit_val), 32'h0310);
    chk("lat_edge6_dp0", 32'(dp[0]), 32'h0);
    drive(4'hE, 8'h81, 4);
    chk("lat_no_tick", 32'(tick_cnt), 32'(t0 + 1));

    // Two anodes low: sticky error, no capture
    drive(4'hC, 8'h81, 8);
    chk("multi_err", 32'(err), 32'h1);
    chk("multi_val", 32'(digit_val), 32'h0310);
    chk("multi_cls", 32'(digit_cls), 32'h40);

    // Vector table through the scoreboard; digit0 is already in the mask
    model_mask = 4'b0001;
    exp_ticks  = tick_cnt;
    for (int i = 0; i < 20; i++) begin
      drive(4'hF, 8'hFF, 2);
      sb.push_back(vecs[i]);
      model_mask = model_mask | (4'b0001 << vecs[i].idx);
      if (model_mask == 4'hF) begin
        exp_ticks++;
        model_mask = 4'h0;
      end
      drive(vecs[i].an, vecs[i].ss, 8);
      e = sb.pop_front();
      chk($sformatf("vec%0d_val", i), 32'(digit_val[e.idx*4 +: 4]), 32'(e.val));
      chk($sformatf("vec%0d_cls", i), 32'(digit_cls[e.idx*2 +: 2]), 32'(e.cls));
      chk($sformatf("vec%0d_dp", i), 32'(dp[e.idx]), 32'(e.dp));
    end
    chk("table_ticks", 32'(tick_cnt), 32'(exp_ticks));
    chk("err_sticky", 32'(err), 32'h1);

    // Reset after two captures discards the partial frame
    drive(4'hE, 8'h81, 8);
    drive(4'hD, 8'h81, 8);
    rst = 1'b1;
    drive(4'hF, 8'hFF, 2);
    chk("rst2_cls", 32'(digit_cls), 32'hAA);
    chk("rst2_val", 32'(digit_val), 32'h0);
    chk("rst2_err", 32'(err), 32'h0);
    chk("rst2_stale", 32'(stale), 32'h0);
    rst = 1'b0;
    t0 = tick_cnt;
    drive(4'hB, 8'h81, 8);
    drive(4'h7, 8'h81, 8);
    drive(4'hB, 8'hCF, 8);
    chk("fresh_no_tick_a", 32'(tick_cnt), 32'(t0));
    drive(4'hE, 8'h81, 8);
    chk("fresh_no_tick_b", 32'(tick_cnt), 32'(t0));
    drive(4'hD, 8'h81, 8);
    chk("fresh_tick", 32'(tick_cnt), 32'(t0 + 1));
    chk("fresh_val", 32'(digit_val), 32'h0100);
    chk("fresh_cls", 32'(digit_cls), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
